// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM-stage controller sitting between the EX/MEM pipeline register and
//   the MEM/WB boundary (the MEM/WB register is folded in here). Loads and
//   stores become word accesses on a variable-latency req/ack data-memory
//   port. The upstream pipeline is stalled while an access is outstanding.
//   Misaligned or aborted accesses retire as bubbles and set a sticky error.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined   : an access left unacknowledged for TIMEOUT request cycles
//                 is aborted in cycle TIMEOUT, retires as a bubble, sets err_o
//     undefined : no counter, accesses wait indefinitely
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   MemtoReg_i/RegWrite_i/
//   MemWrite_i              EX/MEM control (load, writes RD, store)
//   Result_i, Data_i, RD_i  ALU result / address, store data, destination
//   stall_o                 freeze upstream stages this cycle (combinational)
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o data-memory request side
//   mem_ack_i, mem_rdata_i  single-cycle completion and load data
//   MemtoReg_o, RegWrite_o,
//   ReadData_o, Result_o,
//   RD_o                    registered write-back operands
//   err_o                   sticky fault flag (cleared only by reset)
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Result_i,
  input  logic [31:0] Data_i,
  input  logic [4:0]  RD_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] Result_o,
  output logic [4:0]  RD_o,
  output logic        err_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   mem_op, misalign, access, abort;

  assign mem_op   = MemtoReg_i | MemWrite_i;
  assign misalign = mem_op & (Result_i[1:0] != 2'b00);
  assign access   = mem_op & ~misalign;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt, cnt_nxt;
  // cnt counts request cycles already spent unacknowledged, so reaching
  // TIMEOUT-1 in WAIT means the current cycle is request cycle TIMEOUT.
  assign abort = (state == WAIT) && (cnt == 8'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign mem_we_o    = MemWrite_i;
  assign mem_addr_o  = Result_i;
  assign mem_wdata_o = Data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
`ifdef MEM_TIMEOUT_EN
      cnt   <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MEM_TIMEOUT_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt   = cnt;
`endif
    // Request and stall are masked during reset so a reset mid-access
    // releases the memory port and the pipeline immediately.
    mem_req_o = access & ~rst_i & ~abort;
    stall_o   = access & ~mem_ack_i & ~abort & ~rst_i;
    case (state)
      IDLE: begin
        if (access & ~mem_ack_i) begin
          state_nxt = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_nxt   = 8'd1;
`endif
        end
      end
      WAIT: begin
        if (mem_ack_i | abort) begin
          state_nxt = IDLE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_nxt = cnt + 8'd1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      MemtoReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
      ReadData_o <= 32'd0;
      Result_o   <= 32'd0;
      RD_o       <= 5'd0;
      err_o      <= 1'b0;
    end else if (stall_o) begin
      // Instruction still waiting on memory: hand WB a bubble.
      MemtoReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
    end else begin
      Result_o <= Result_i;
      RD_o     <= RD_i;
      if (misalign | abort) begin
        MemtoReg_o <= 1'b0;
        RegWrite_o <= 1'b0;
        err_o      <= 1'b1;
      end else begin
        MemtoReg_o <= MemtoReg_i;
        RegWrite_o <= RegWrite_i;
        // Unstalled, non-aborted aligned load implies the ack is here.
        if (MemtoReg_i & mem_ack_i) begin
          ReadData_o <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller between the EX/MEM pipeline register and the MEM/WB boundary. It takes load/store/ALU results, runs word accesses on a variable-latency data-memory req/ack port, and stalls the upstream pipeline while an access is outstanding. It registers write-back operands (MEM/WB register folded in) and flags misaligned or timed-out accesses.

## Interface
- TIMEOUT, 16: max cycles a request may stay unacknowledged (used only with MEM_TIMEOUT_EN); legal 2..255.
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- MemtoReg_i  in  1  instruction is a load.
- RegWrite_i  in  1  instruction writes RD.
- MemWrite_i  in  1  instruction is a store.
- Result_i  in  32  ALU result / memory address.
- Data_i  in  32  store data.
- RD_i  in  5  destination register.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle (combinational).
- mem_req_o  out  1  data-memory request (combinational).
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  = Result_i.
- mem_wdata_o  out  32  = Data_i.
- mem_ack_i  in  1  single-cycle completion; rdata valid same cycle.
- mem_rdata_i  in  32  load data.
- MemtoReg_o, RegWrite_o  out  1 each  registered WB controls.
- ReadData_o  out  32  registered load data.
- Result_o  out  32  registered ALU result.
- RD_o  out  5  registered destination.
- err_o  out  1  sticky fault flag.

## Operation
- access = (MemtoReg_i | MemWrite_i) & ~misalign; misalign = (MemtoReg_i | MemWrite_i) & (Result_i[1:0] != 0).
- FSM states: IDLE (no access outstanding before this cycle), WAIT (request issued in an earlier cycle, no ack yet).
- IDLE: access & ~mem_ack_i -> WAIT, cnt <= 1; else stay IDLE.
- WAIT: mem_ack_i -> IDLE; timeout (cnt == TIMEOUT-1, macro only) -> IDLE; else cnt <= cnt+1.
- mem_req_o = access & ~rst_i & ~abort, where abort = timeout condition this cycle; mem_we_o = MemWrite_i.
- stall_o = access & ~mem_ack_i & ~abort. EX/MEM inputs stay stable during stall.
- WB register load each posedge:
  - Stalled cycle: bubble (RegWrite_o = 0, MemtoReg_o = 0; other fields don't-care, held).
  - Otherwise: MemtoReg_i, RegWrite_i, Result_i, RD_i; ReadData_o <= mem_rdata_i when load acked.
  - Misaligned or aborted instruction: retire with RegWrite_o = 0, MemtoReg_o = 0, no memory request; err_o <= 1.
- ALU-only instructions pass through with no request and no stall.
- Back-to-back accesses: req stays high across ack posedge; memory must treat the cycle after an ack as a new request.

## Timing
- Reset (async): state IDLE, cnt 0, all registered outputs 0, err_o 0; mem_req_o and stall_o forced 0 while rst_i high. Reset mid-access abandons it; the memory must drop the pending transfer.
- Latency: ALU op and zero-wait access (ack in request cycle) retire to WB 1 cycle after arrival, no stall.
- Ack on request cycle k (k=1 = first cycle): stall_o high cycles 1..k-1, low on k; WB valid after posedge ending cycle k.
- err_o clears only on reset.

## Configuration
- MEM_TIMEOUT_EN defined: cycle counter active; an access unacked for TIMEOUT request cycles aborts in cycle TIMEOUT (req and stall low that cycle), retires as a bubble, and sets err_o. Late ack after abort is ignored by the memory contract.
- Undefined: no counter; waits indefinitely; err_o reports misalignment only.

## Test plan
- ALU op Result_i=0x1234, RD_i=5, RegWrite_i=1 -> next cycle Result_o=0x1234, RD_o=5, RegWrite_o=1, stall_o never high.
- Load addr 0x40, ack in 3rd request cycle with rdata 0xDEADBEEF -> stall_o high 2 cycles, then ReadData_o=0xDEADBEEF, MemtoReg_o=1.
- Store addr 0x80, data 0x55, zero-wait ack -> mem_we_o=1, mem_wdata_o=0x55, no stall, RegWrite_o=0.
- Load addr 0x42 -> no mem_req_o, err_o=1, retires RegWrite_o=0; next instruction proceeds normally.
- With MEM_TIMEOUT_EN, TIMEOUT=4, never ack -> stall 3 cycles, abort cycle 4, err_o=1; without macro stall persists 100+ cycles.
- Assert rst_i during WAIT -> mem_req_o, stall_o, err_o, all WB outputs 0 immediately; state IDLE after release.
